// File: rtl/aes_session_ctrl_if.sv
// Bus bundle between the SPI slave / AES core side and the session controller.
// Latency: none; this is wiring only.
// Backpressure: none; frames and core completions are single-cycle pulses.
//
// Signals:
//   cs           SPI chip select, active-low, already in the clk domain
//   frame_valid  1-cycle pulse: a 128-bit receive frame is complete
//   frame_data   received frame, valid with frame_valid
//   aes_start    1-cycle pulse: core begins encryption
//   aes_key      key presented to the core
//   aes_block    plaintext presented to the core
//   aes_done     1-cycle pulse from the core: aes_result is valid
//   aes_result   ciphertext from the core
//   tx_data      ciphertext presented to the SPI send path
//   tx_ready     tx_data holds fresh ciphertext awaiting readback
//   busy         controller is inside a session (not waiting for a frame)
//   err_timeout  sticky: core did not finish in time
//   err_overrun  sticky: a frame arrived while frames were not accepted
//
// The controller uses the slave modport; the surroundings use master.
interface aes_session_ctrl_if;
  logic         cs;
  logic         frame_valid;
  logic [127:0] frame_data;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_block;
  logic         aes_done;
  logic [127:0] aes_result;
  logic [127:0] tx_data;
  logic         tx_ready;
  logic         busy;
  logic         err_timeout;
  logic         err_overrun;

  modport slave (
    input  cs,
    input  frame_valid,
    input  frame_data,
    input  aes_done,
    input  aes_result,
    output aes_start,
    output aes_key,
    output aes_block,
    output tx_data,
    output tx_ready,
    output busy,
    output err_timeout,
    output err_overrun
  );

  modport master (
    output cs,
    output frame_valid,
    output frame_data,
    output aes_done,
    output aes_result,
    input  aes_start,
    input  aes_key,
    input  aes_block,
    input  tx_data,
    input  tx_ready,
    input  busy,
    input  err_timeout,
    input  err_overrun
  );
endinterface

// File: rtl/aes_session_ctrl.sv
// Sequences one AES session: key frame, plaintext frames, core run, ciphertext readback.
// Latency: plaintext frame -> aes_start 1 cycle; aes_done -> tx_ready 1 cycle; cs high in SEND -> idle 1 cycle.
// Backpressure: none; frames arriving mid-session are dropped and flagged in err_overrun.
//
// Ports:
//   clk    system clock, all logic on posedge
//   reset  asynchronous, active-low
//   bus    aes_session_ctrl_if.slave (SPI frame input, core control, readback, status)
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in WAIT_CORE before the session is aborted (>= 1)
//   CNT_W           timeout counter width, 2**CNT_W must exceed TIMEOUT_CYCLES
//   KEY_REUSE       1: keep the key and wait for another plaintext after readback
//                   0: require a fresh key frame after every readback
module aes_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8,
  parameter bit KEY_REUSE      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  aes_session_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_KEY  = 3'd0,
    WAIT_PT   = 3'd1,
    START     = 3'd2,
    WAIT_CORE = 3'd3,
    READY_TX  = 3'd4,
    SEND      = 3'd5
  } state_t;

  // Counter value seen on the last cycle the core is allowed to run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Where a completed readback returns to.
  localparam state_t IDLE_AFTER_TX = KEY_REUSE ? WAIT_PT : WAIT_KEY;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Single sequential block: state, counter and every output are registered.
  // busy is computed from the next state so it lines up with the state
  // register rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= WAIT_KEY;
      cnt             <= '0;
      bus.aes_start   <= 1'b0;
      bus.aes_key     <= '0;
      bus.aes_block   <= '0;
      bus.tx_data     <= '0;
      bus.tx_ready    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      // aes_start is high only during the START cycle.
      bus.aes_start <= 1'b0;

      case (state)
        WAIT_KEY: begin
          if (bus.frame_valid) begin
            bus.aes_key <= bus.frame_data;
            state       <= WAIT_PT;
          end
        end

        WAIT_PT: begin
          if (bus.frame_valid) begin
            bus.aes_block <= bus.frame_data;
            bus.aes_start <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= START;
          end
        end

        START: begin
          cnt   <= '0;
          state <= WAIT_CORE;
          if (bus.frame_valid) begin
            bus.err_overrun <= 1'b1;
          end
        end

        WAIT_CORE: begin
          cnt <= cnt + 1'b1;
          if (bus.frame_valid) begin
            bus.err_overrun <= 1'b1;
          end
          // A completion on the timeout cycle still counts as success.
          if (bus.aes_done) begin
            bus.tx_data  <= bus.aes_result;
            bus.tx_ready <= 1'b1;
            state        <= READY_TX;
          end else if (cnt == CNT_LAST) begin
            // Abort: the key is no longer trusted, so a new key frame is needed.
            bus.err_timeout <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= WAIT_KEY;
          end
        end

        READY_TX: begin
          if (bus.frame_valid) begin
            bus.err_overrun <= 1'b1;
          end
          if (!bus.cs) begin
            state <= SEND;
          end
        end

        SEND: begin
          if (bus.frame_valid) begin
            bus.err_overrun <= 1'b1;
          end
          // cs returning high marks the end of the readback transfer.
          if (bus.cs) begin
            bus.tx_ready <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= IDLE_AFTER_TX;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= WAIT_KEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_session_ctrl.sv
module tb_aes_session_ctrl;

  logic clk;
  logic reset;

  aes_session_ctrl_if bus ();

  aes_session_ctrl #(
    .TIMEOUT_CYCLES(64),
    .CNT_W(8),
    .KEY_REUSE(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] CT2  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] PT3  = 128'h11111111222222223333333344444444;
  localparam logic [127:0] CT3  = 128'haaaaaaaabbbbbbbbccccccccdddddddd;
  localparam logic [127:0] PT4  = 128'h55555555666666667777777788888888;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT5  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT5  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY3 = 128'hcafebabecafebabecafebabecafebabe;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All stimulus changes happen just after a falling edge; outputs are
  // therefore sampled half a cycle away from the rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [127:0] d);
    bus.frame_valid = 1'b1;
    bus.frame_data  = d;
    tick();
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
  endtask

  task automatic core_done(input logic [127:0] r);
    bus.aes_done   = 1'b1;
    bus.aes_result = r;
    tick();
    bus.aes_done   = 1'b0;
    bus.aes_result = '0;
  endtask

  task automatic readback(input string tag);
    bus.cs = 1'b0;
    tick();
    check({tag, "_sendrdy"}, 128'(bus.tx_ready), 128'd1);
    check({tag, "_sendbusy"}, 128'(bus.busy), 128'd1);
    bus.cs = 1'b1;
    tick();
    check({tag, "_rdyclr"}, 128'(bus.tx_ready), 128'd0);
    check({tag, "_idle"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.cs         = 1'b1;
    bus.frame_valid = 1'b0;
    bus.frame_data = '0;
    bus.aes_done   = 1'b0;
    bus.aes_result = '0;
    repeat (3) tick();

    // Reset values.
    check("rst_key",   bus.aes_key, '0);
    check("rst_block", bus.aes_block, '0);
    check("rst_tx",    bus.tx_data, '0);
    check("rst_flags", {123'd0, bus.aes_start, bus.tx_ready, bus.busy,
                        bus.err_timeout, bus.err_overrun}, '0);
    reset = 1'b1;
    tick();

    // 1: key then plaintext; start pulses one cycle after the plaintext frame.
    send_frame(KEY1);
    check("t1_key", bus.aes_key, KEY1);
    check("t1_kbusy", 128'(bus.busy), 128'd0);
    check("t1_nostart", 128'(bus.aes_start), 128'd0);
    send_frame(PT1);
    check("t1_start", 128'(bus.aes_start), 128'd1);
    check("t1_block", bus.aes_block, PT1);
    check("t1_busy", 128'(bus.busy), 128'd1);
    tick();
    check("t1_start_once", 128'(bus.aes_start), 128'd0);

    // 2: core answers after 10 cycles; readback returns to WAIT_PT with key kept.
    repeat (8) tick();
    check("t2_notready", 128'(bus.tx_ready), 128'd0);
    core_done(CT1);
    check("t2_tx", bus.tx_data, CT1);
    check("t2_rdy", 128'(bus.tx_ready), 128'd1);
    tick();
    check("t2_hold", 128'(bus.tx_ready), 128'd1);
    readback("t2");
    check("t2_keykept", bus.aes_key, KEY1);

    // 5: a frame during WAIT_CORE is dropped and flagged; session still completes.
    // Being in WAIT_PT is shown by the next frame landing in aes_block.
    send_frame(PT2);
    check("t5_start", 128'(bus.aes_start), 128'd1);
    check("t5_block", bus.aes_block, PT2);
    tick();
    send_frame(JUNK);
    check("t5_ovr", 128'(bus.err_overrun), 128'd1);
    check("t5_blockkept", bus.aes_block, PT2);
    check("t5_keykept", bus.aes_key, KEY1);
    check("t5_busy", 128'(bus.busy), 128'd1);
    repeat (2) tick();
    core_done(CT2);
    check("t5_tx", bus.tx_data, CT2);
    check("t5_rdy", 128'(bus.tx_ready), 128'd1);
    readback("t5");
    check("t5_ovrsticky", 128'(bus.err_overrun), 128'd1);

    // 4: done on the very cycle the timeout would fire (counter at 63).
    send_frame(PT3);
    repeat (64) tick();
    core_done(CT3);
    check("t4_noto", 128'(bus.err_timeout), 128'd0);
    check("t4_rdy", 128'(bus.tx_ready), 128'd1);
    check("t4_tx", bus.tx_data, CT3);
    readback("t4");

    // 3: no done; timeout fires 64 cycles after the START cycle ends.
    send_frame(PT4);
    check("t3_start", 128'(bus.aes_start), 128'd1);
    repeat (64) tick();
    check("t3_early", 128'(bus.err_timeout), 128'd0);
    check("t3_busy_pre", 128'(bus.busy), 128'd1);
    tick();
    check("t3_to", 128'(bus.err_timeout), 128'd1);
    check("t3_busy", 128'(bus.busy), 128'd0);
    check("t3_txkept", bus.tx_data, CT3);
    check("t3_rdy", 128'(bus.tx_ready), 128'd0);
    // Back in WAIT_KEY: the next frame is taken as a key, not plaintext.
    send_frame(KEY2);
    check("t3_newkey", bus.aes_key, KEY2);
    check("t3_blockkept", bus.aes_block, PT4);
    check("t3_nostart", 128'(bus.aes_start), 128'd0);
    // aes_done outside WAIT_CORE changes nothing.
    core_done(CT5);
    check("t3_strayd", bus.tx_data, CT3);
    check("t3_tosticky", 128'(bus.err_timeout), 128'd1);

    // 6: reset in the middle of WAIT_CORE.
    send_frame(PT5);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("t6_key",   bus.aes_key, '0);
    check("t6_block", bus.aes_block, '0);
    check("t6_tx",    bus.tx_data, '0);
    check("t6_flags", {123'd0, bus.aes_start, bus.tx_ready, bus.busy,
                       bus.err_timeout, bus.err_overrun}, '0);
    tick();
    reset = 1'b1;
    tick();
    core_done(CT5);
    check("t6_lated_rdy", 128'(bus.tx_ready), 128'd0);
    check("t6_lated_tx", bus.tx_data, '0);
    check("t6_lated_busy", 128'(bus.busy), 128'd0);
    send_frame(KEY3);
    check("t6_newkey", bus.aes_key, KEY3);
    send_frame(PT1);
    check("t6_start", 128'(bus.aes_start), 128'd1);
    check("t6_block", bus.aes_block, PT1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
